sub_result_stage: RTL
=====================

# sub_result_stage

Registered output stage directly downstream of the 64-bit subtractor. It captures the difference and carry-out, derives the condition flags, and presents them to the consumer through a valid/ready handshake. A 2-entry skid buffer lets the stage accept at full throughput and absorb one beat of backpressure without a combinational ready path.

## Interface
- WIDTH, 64: datapath width of the difference.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the subtractor result on in_* is valid.
- in_ready  out  1  the stage can accept a beat.
- in_diff  in  WIDTH  subtractor difference S.
- in_carry  in  1  subtractor carry-out C. C=1 means a ≥ b unsigned, i.e. no borrow.
- in_a_sign  in  1  bit WIDTH-1 of minuend a.
- in_b_sign  in  1  bit WIDTH-1 of subtrahend b.
- out_valid  out  1  the output beat is valid.
- out_ready  in  1  the consumer accepts the beat.
- out_diff  out  WIDTH  registered difference.
- out_flags  out  4  {V, N, Z, C}.
- ovf_sticky  out  1  sticky overflow. Present only with the macro.
- ovf_clr  in  1  clears ovf_sticky. Present only with the macro.

## Operation
- Flags are computed combinationally from the in_* signals and registered together with the difference:
  - C = in_carry.
  - Z = (in_diff == 0).
  - N = in_diff[WIDTH-1].
  - V = (in_a_sign != in_b_sign) && (in_diff[WIDTH-1] != in_a_sign).
- Storage is a main register (drives out_*) and a skid register. Each holds WIDTH+4 bits plus a valid bit.
- State machine:
  - EMPTY: main and skid both invalid.
  - ONE: main valid, skid invalid.
  - FULL: main and skid both valid.
- Transitions (acc = in_valid && in_ready, pop = out_valid && out_ready):
  - EMPTY: acc → ONE, the beat loads main.
  - ONE: acc && !pop → FULL, the beat loads skid. acc && pop → ONE, the beat loads main. pop only → EMPTY.
  - FULL: pop → ONE, skid moves to main. acc cannot occur because in_ready = 0.
- in_ready = !skid_valid, driven from the register only. It has no combinational path from out_ready.
- out_valid = main_valid.
- Beats leave the stage in acceptance order. No beat is dropped or duplicated.
- out_diff and out_flags hold their value while out_valid && !out_ready.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is on out_* after edge k, when the stage was EMPTY or popped at the same edge.
- Throughput is 1 beat/cycle while out_ready is held at 1.
- Reset (rst high at a clock edge):
  - State becomes EMPTY.
  - out_valid = 0, in_ready = 1, out_diff = 0, out_flags = 4'b0000, ovf_sticky = 0.
  - Inputs are ignored while rst is high.
- Reset mid-operation discards both buffered beats without presenting them.
- While out_valid = 0, out_diff and out_flags keep their last value. Consumers must not use them.
- Simultaneous acc and pop in ONE: the new beat replaces main at the same edge and state stays ONE.

## Configuration
- SUB_RESULT_STICKY_OVF_EN, defined:
  - Adds ovf_clr and ovf_sticky.
  - ovf_sticky sets on any pop with V = 1 and holds until the ovf_clr edge or reset.
  - ovf_clr and a set at the same edge: set wins.
- SUB_RESULT_STICKY_OVF_EN, undefined: the ports and register are absent. All other behaviour is identical.

## Test plan
- Borrow case: in_diff = 0xFFFF_FFFF_FFFF_F6EF (10024 − 12345), C = 0, signs 0/0, out_ready = 1.
  - Required: one cycle later out_valid = 1, out_diff = 0xFFFF_FFFF_FFFF_F6EF, flags {V,N,Z,C} = 0100.
- No-borrow case: in_diff = 0x9D6B (78120 − 37821), C = 1.
  - Required: flags = 0001.
- Zero case: a = b = 5, in_diff = 0, C = 1.
  - Required: flags = 0011.
- Overflow case: a = 0x8000_0000_0000_0000, b = 1, in_diff = 0x7FFF_FFFF_FFFF_FFFF, C = 1, signs 1/0.
  - Required: flags = 1001.
  - With the macro: ovf_sticky = 1 after the pop, back to 0 one edge after ovf_clr = 1.
- Backpressure: stream 4 beats with out_ready = 0.
  - Required: in_ready drops after 2 acceptances.
  - Required: after out_ready = 1, the beats emerge in order on consecutive cycles, none lost.
- Reset in FULL: assert rst for one edge.
  - Required: out_valid = 0, in_ready = 1, out_flags = 0000 next cycle, and the buffered beats never appear.

Source files
------------

// File: rtl/sub_result_stage.sv
// Registered output stage behind the 64-bit subtractor: captures the difference
// and derives {V,N,Z,C}. It also adds a 2-entry skid buffer on a valid/ready handshake.
// Optional sticky overflow flag: define SUB_RESULT_STICKY_OVF_EN.
module sub_result_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_diff,
    input  logic             in_carry,
    input  logic             in_a_sign,
    input  logic             in_b_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic [3:0]       out_flags
`ifdef SUB_RESULT_STICKY_OVF_EN
    ,
    output logic             ovf_sticky,
    input  logic             ovf_clr
`endif
);

    // Handshake: a beat moves across a port on any rising edge where valid and
    // ready are both high. Valid never depends on ready. in_ready comes only
    // from the state register, never from out_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH+3:0] main_data, skid_data;
    logic [WIDTH+3:0] in_beat;
    logic [3:0]       in_flags;
    logic             main_valid, skid_valid;
    logic             acc, pop;
    logic             load_main_in, load_main_skid, load_skid;

    assign in_flags = {(in_a_sign != in_b_sign) && (in_diff[WIDTH-1] != in_a_sign),
                       in_diff[WIDTH-1],
                       (in_diff == '0),
                       in_carry};
    assign in_beat  = {in_flags, in_diff};

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);
    assign in_ready   = !skid_valid;
    assign out_valid  = main_valid;
    assign out_diff   = main_data[WIDTH-1:0];
    assign out_flags  = main_data[WIDTH+3:WIDTH];

    assign acc = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= next_state;
    end

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    next_state   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (acc && !pop) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (acc && pop) begin
                    load_main_in = 1'b1;
                end else if (pop) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    next_state     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Registers keep their contents when not loaded, so out_* hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (load_main_in)        main_data <= in_beat;
            else if (load_main_skid) main_data <= skid_data;
            if (load_skid)           skid_data <= in_beat;
        end
    end

`ifdef SUB_RESULT_STICKY_OVF_EN
    // A set on a popped overflow beat takes priority over a same-edge clear.
    always_ff @(posedge clk) begin
        if (rst)                              ovf_sticky <= 1'b0;
        else if (pop && main_data[WIDTH+3])   ovf_sticky <= 1'b1;
        else if (ovf_clr)                     ovf_sticky <= 1'b0;
    end
`endif

endmodule
